abs_neg_serial: RTL and testbench
=================================

Name: abs_neg_serial

Overview:
- Parametrised, chunk-serial two's-complement magnitude/negation unit; successor to the 8-bit combinational absolute-value block.
- Processes a WIDTH-bit signed operand CHUNK bits per clock, LSB chunk first, with a ripple carry held in a flop between chunks.
- Four operation modes; flags results that cannot be represented.
- Sits between producer and consumer datapath stages behind valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits; must be at least 2.
- CHUNK, 4, bits processed per CALC cycle; must divide WIDTH exactly; CHUNK = WIDTH is legal and gives one CALC cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an operand.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  signed operand, two's complement.
- in_mode  input  2  operation: 00 pass, 01 abs, 10 negate, 11 negative magnitude (-|a|).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  result not representable in WIDTH bits.
- out_sign  output  1  sign bit of the accepted operand.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst_n = 0):
  - state goes to IDLE.
  - in_ready is 1; out_valid, out_ovf, out_sign and busy are 0; out_data is 0.
  - Internal operand, carry and chunk counter are cleared.
  - Reset asserted mid-CALC or mid-DONE discards the operation; no partial output appears.
- Derived value: NCHUNK = WIDTH/CHUNK.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T:
    - latch in_data and in_mode;
    - compute the invert decision inv (see mode rules);
    - set carry = inv;
    - clear the chunk counter;
    - go to CALC.
- CALC (cycles T+1 .. T+NCHUNK):
  - in_ready = 0.
  - Each cycle, chunk k: result_chunk = (inv ? ~op_chunk : op_chunk) + carry; the carry-out is stored.
  - The counter increments each cycle.
  - After chunk NCHUNK-1, go to DONE.
  - The final carry-out is discarded.
- DONE:
  - out_valid = 1 from cycle T+NCHUNK+1; out_data, out_ovf and out_sign are stable while out_valid is high.
  - On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE, so there is no overlap.
  - Minimum throughput: one operation per NCHUNK+2 cycles.
  - Backpressure: DONE holds indefinitely while out_ready = 0.
- Mode rules (s = operand sign bit):
  - 00: inv = 0.
  - 01: inv = s.
  - 10: inv = 1.
  - 11: inv = ~s.
  - Zero operand in mode 10 or 11 gives 0, carry wraps, no ovf.
- Overflow:
  - out_ovf = 1 iff mode is 01 or 10 and the operand equals the most negative value (MSB 1, rest 0).
  - Mode 11 never overflows: the most negative value passes through, and -(max positive) is representable.
  - Mode 00 never overflows.
  - out_ovf is computed at acceptance and registered.
- out_sign: registered copy of operand bit WIDTH-1.
- out_data updates only in DONE entry / CALC.
  - Between operations it holds the last result until the next CALC begins overwriting chunks.
  - Consumers sample it only with out_valid.
- Simultaneous events:
  - in_valid while busy: ignored; the producer must hold it.
  - out_ready while not out_valid: no effect.

Optional Feature:
- Macro: ABS_NEG_SAT_EN.
- Defined: when out_ovf = 1, out_data is forced to the maximum positive value (MSB 0, rest 1) at DONE entry; out_ovf is still reported.
- Undefined: overflow wraps, so out_data equals the most negative value unchanged, with out_ovf = 1.
- No timing difference either way.

Test Plan (WIDTH=8, CHUNK=4 unless noted):
- Reset then accept 8'hF6, mode 01, at cycle T; out_ready = 1 -> out_valid first high at T+3 with out_data 8'h0A, out_ovf 0, out_sign 1; in_ready back to 1 at T+4.
- 8'h80, mode 01 -> out_ovf 1; out_data 8'h80 without the macro, 8'h7F with ABS_NEG_SAT_EN; repeat with mode 10 for the same result; mode 11 -> 8'h80, ovf 0.
- Mode sweep on 8'h05: 00 -> 8'h05; 01 -> 8'h05; 10 -> 8'hFB; 11 -> 8'hFB. Also 8'h00 in mode 10 -> 8'h00, ovf 0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_valid and out_data stay constant, in_ready stays 0, and a second in_valid is not accepted until one cycle after the out_ready handshake.
- Reset pulse mid-CALC (cycle T+1) -> out_valid never asserts, state IDLE, in_ready 1; the next operation 8'hFF, mode 01 -> 8'h01.
- Parameter variants: WIDTH=16, CHUNK=16 with 16'h8001, mode 01 -> 16'h7FFF at T+2; WIDTH=12, CHUNK=3 with 12'hFFF, mode 10 -> 12'h001 at T+5.

Source files
------------

// File: rtl/abs_neg_serial.sv
// abs_neg_serial: chunk-serial two's-complement pass / abs / negate / -|a| unit.
// The operand is consumed CHUNK bits per clock, LSB chunk first, with the
// ripple carry held in a flop between chunks. Valid/ready on both sides.
// Optional feature: define ABS_NEG_SAT_EN to saturate overflowing results to
// the maximum positive value; otherwise they wrap to the most negative value.
module abs_neg_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_sign,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ABS_NEG_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_ABS  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_NMAG = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q,    op_d;     // operand, shifted right one chunk per CALC cycle
    logic [WIDTH-1:0] res_q,   res_d;    // result, filled from the top one chunk per CALC cycle
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             inv_q,   inv_d;
    logic             carry_q, carry_d;
    logic             ovf_q,   ovf_d;
    logic             sign_q,  sign_d;

    logic             in_sign;
    logic             in_inv;
    logic             in_ovf;
    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK:0]   chunk_sum;

    // Acceptance-time decode: invert decision and overflow flag from mode and sign.
    always_comb begin
        in_sign = in_data[WIDTH-1];
        in_inv  = 1'b0;
        in_ovf  = 1'b0;
        case (mode_t'(in_mode))
            MODE_PASS: in_inv = 1'b0;
            MODE_ABS: begin
                in_inv = in_sign;
                in_ovf = (in_data == MOST_NEG);
            end
            MODE_NEG: begin
                in_inv = 1'b1;
                in_ovf = (in_data == MOST_NEG);
            end
            MODE_NMAG: in_inv = ~in_sign;
            default:   in_inv = 1'b0;
        endcase
    end

    // Next-state and datapath: one chunk of (inv ? ~op : op) + carry per CALC cycle.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        inv_d     = inv_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        sign_d    = sign_q;
        chunk_in  = op_q[CHUNK-1:0] ^ {CHUNK{inv_q}};
        chunk_sum = (CHUNK+1)'(chunk_in) + (CHUNK+1)'(carry_q);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_data;
                    inv_d   = in_inv;
                    carry_d = in_inv;
                    ovf_d   = in_ovf;
                    sign_d  = in_sign;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                res_d   = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                op_d    = op_q >> CHUNK;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final carry-out is meaningless (zero negation wraps); it is dropped.
                    state_d = ST_DONE;
`ifdef ABS_NEG_SAT_EN
                    if (ovf_q) begin
                        res_d = MAX_POS;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            sign_q  <= sign_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = res_q;
    assign out_ovf   = ovf_q;
    assign out_sign  = sign_q;

endmodule

// File: tb/tb_abs_neg_serial.sv
// Directed bench for abs_neg_serial: default 8/4 instance plus 16/16 and 12/3
// parameter variants. Inputs are driven and outputs sampled 1 ns after posedge.
module tb_abs_neg_serial;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

`ifdef ABS_NEG_SAT_EN
    localparam logic [7:0] OVF8_RES = 8'h7F;
`else
    localparam logic [7:0] OVF8_RES = 8'h80;
`endif

    // 8-bit, 4-bit chunk instance
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_in_mode;
    logic       a_out_ovf, a_out_sign, a_busy;

    // 16-bit, single chunk instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_in_mode;
    logic        b_out_ovf, b_out_sign, b_busy;

    // 12-bit, 3-bit chunk instance
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [11:0] c_in_data, c_out_data;
    logic [1:0]  c_in_mode;
    logic        c_out_ovf, c_out_sign, c_busy;

    abs_neg_serial #(.WIDTH(8), .CHUNK(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ovf(a_out_ovf), .out_sign(a_out_sign), .busy(a_busy)
    );

    abs_neg_serial #(.WIDTH(16), .CHUNK(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf), .out_sign(b_out_sign), .busy(b_busy)
    );

    abs_neg_serial #(.WIDTH(12), .CHUNK(3)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_mode(c_in_mode),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_ovf(c_out_ovf), .out_sign(c_out_sign), .busy(c_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation on the 8-bit instance with out_ready held high.
    // Latency counts posedges after the accepting edge until out_valid is seen;
    // DONE is entered NCHUNK edges after acceptance.
    task automatic run8(input string tag, input logic [7:0] data, input logic [1:0] mode,
                        input logic [7:0] exp_data, input logic exp_ovf, input logic exp_sign);
        int lat;
        check({tag, "_ready_before"}, a_in_ready, 1);
        a_in_data  = data;
        a_in_mode  = mode;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check({tag, "_busy"}, a_busy, 1);
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_data"}, a_out_data, exp_data);
        check({tag, "_ovf"},  a_out_ovf,  exp_ovf);
        check({tag, "_sign"}, a_out_sign, exp_sign);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, a_out_valid, 0);
        check({tag, "_ready_after"}, a_in_ready, 1);
    endtask

    initial begin
        int  lat;
        logic seen;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_mode = '0; c_out_ready = 1'b1;

        #12;
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_ovf",   a_out_ovf,   0);
        check("rst_out_sign",  a_out_sign,  0);
        check("rst_busy",      a_busy,      0);
        check("rst_out_data",  a_out_data,  0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic abs, overflow corner, mode sweep
        run8("abs_f6",    8'hF6, 2'b01, 8'h0A,    1'b0, 1'b1);
        run8("abs_80",    8'h80, 2'b01, OVF8_RES, 1'b1, 1'b1);
        run8("neg_80",    8'h80, 2'b10, OVF8_RES, 1'b1, 1'b1);
        run8("nmag_80",   8'h80, 2'b11, 8'h80,    1'b0, 1'b1);
        run8("pass_05",   8'h05, 2'b00, 8'h05,    1'b0, 1'b0);
        run8("abs_05",    8'h05, 2'b01, 8'h05,    1'b0, 1'b0);
        run8("neg_05",    8'h05, 2'b10, 8'hFB,    1'b0, 1'b0);
        run8("nmag_05",   8'h05, 2'b11, 8'hFB,    1'b0, 1'b0);
        run8("neg_00",    8'h00, 2'b10, 8'h00,    1'b0, 1'b0);
        run8("nmag_00",   8'h00, 2'b11, 8'h00,    1'b0, 1'b0);
        run8("nmag_7f",   8'h7F, 2'b11, 8'h81,    1'b0, 1'b0);
        run8("abs_81",    8'h81, 2'b01, 8'h7F,    1'b0, 1'b1);
        run8("pass_80",   8'h80, 2'b00, 8'h80,    1'b0, 1'b1);

        // Backpressure: hold out_ready low 5 cycles while a second operand waits
        a_out_ready = 1'b0;
        a_in_data   = 8'h3C;
        a_in_mode   = 2'b10;
        a_in_valid  = 1'b1;
        @(posedge clk); #1;
        a_in_data = 8'h11;
        a_in_mode = 2'b00;
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, 2);
        check("bp_data", a_out_data, 8'hC4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", a_out_valid, 1);
            check("bp_hold_data",  a_out_data,  8'hC4);
            check("bp_hold_ready", a_in_ready,  0);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", a_out_valid, 0);
        check("bp_second_waiting", a_busy, 0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("bp_second_accepted", a_busy, 1);
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_second_latency", lat, 2);
        check("bp_second_data", a_out_data, 8'h11);
        @(posedge clk); #1;

        // Reset pulse one cycle into CALC discards the operation
        a_in_data  = 8'h80;
        a_in_mode  = 2'b01;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("midrst_in_ready",  a_in_ready,  1);
        check("midrst_busy",      a_busy,      0);
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_out_data",  a_out_data,  0);
        check("midrst_out_ovf",   a_out_ovf,   0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (a_out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        run8("after_rst_ff", 8'hFF, 2'b01, 8'h01, 1'b0, 1'b1);

        // WIDTH=16, CHUNK=16: single CALC cycle
        b_in_data  = 16'h8001;
        b_in_mode  = 2'b01;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16_latency", lat, 1);
        check("w16_data", b_out_data, 16'h7FFF);
        check("w16_ovf",  b_out_ovf,  0);
        check("w16_sign", b_out_sign, 1);
        @(posedge clk); #1;
        check("w16_ready_after", b_in_ready, 1);

        // WIDTH=12, CHUNK=3: four CALC cycles, carry ripples through all chunks
        c_in_data  = 12'hFFF;
        c_in_mode  = 2'b10;
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        lat = 0;
        while (!c_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w12_latency", lat, 4);
        check("w12_data", c_out_data, 12'h001);
        check("w12_ovf",  c_out_ovf,  0);
        check("w12_sign", c_out_sign, 1);
        @(posedge clk); #1;
        check("w12_ready_after", c_in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
